// File: rtl/svm_sv_sequencer_pkg.sv
// Shared widths, MEM_W field offsets, sequencer states and the SV model
// contents used to fill the SV ROM.
package svm_sv_sequencer_pkg;

  localparam int SVM_PARAM_WIDTH     = 16;
  localparam int SVM_PARAM_COUNT     = 3;
  localparam int SVM_CLASS_COUNT     = 16;
  localparam int SVM_CLASS_WIDTH     = $clog2(SVM_CLASS_COUNT);
  localparam int SVM_COEF_WIDTH_INT  = 8;
  localparam int SVM_COEF_WIDTH_FRAC = 8;
  localparam int SVM_COEF_SIGN_WIDTH = 4;
  localparam int SVM_SV_COUNT        = 4;
  localparam int SVM_SV_ADDR_WIDTH   = 2;

  localparam int SVM_X_W    = SVM_PARAM_WIDTH * SVM_PARAM_COUNT;
  localparam int SVM_COEF_W = SVM_COEF_WIDTH_INT + SVM_COEF_WIDTH_FRAC;
  localparam int SVM_MEM_W  = SVM_X_W + SVM_CLASS_WIDTH + SVM_COEF_W + SVM_COEF_SIGN_WIDTH;

  // sv_word layout, MSB to LSB: sv | sv_class | coef | coef_sign
  localparam int SVM_SIGN_LSB  = 0;
  localparam int SVM_COEF_LSB  = SVM_SIGN_LSB + SVM_COEF_SIGN_WIDTH;
  localparam int SVM_CLASS_LSB = SVM_COEF_LSB + SVM_COEF_W;
  localparam int SVM_SV_LSB    = SVM_CLASS_LSB + SVM_CLASS_WIDTH;

  localparam logic [SVM_COEF_SIGN_WIDTH-1:0] SVM_SIGN_PATTERN = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } seq_state_e;

  function automatic logic [SVM_MEM_W-1:0] svm_model_word(input int unsigned k);
    logic [SVM_PARAM_WIDTH-1:0] f0;
    logic [SVM_PARAM_WIDTH-1:0] f1;
    logic [SVM_PARAM_WIDTH-1:0] f2;
    f0 = SVM_PARAM_WIDTH'(32'h1000 + k);
    f1 = SVM_PARAM_WIDTH'(32'h2000 + k);
    f2 = SVM_PARAM_WIDTH'(32'h3000 + k);
    return {f0, f1, f2, SVM_CLASS_WIDTH'(k), SVM_COEF_W'(32'h0100 * (k + 1)), SVM_SIGN_PATTERN};
  endfunction

endpackage

// File: rtl/svm_sv_rom.sv
// Support-vector store: synchronous ROM, word available one cycle after rd_en.
import svm_sv_sequencer_pkg::*;

module svm_sv_rom #(
  parameter int DEPTH = SVM_SV_COUNT,
  parameter int AW    = SVM_SV_ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_en,
  input  logic [AW-1:0]        addr,
  output logic [SVM_MEM_W-1:0] word
);

  logic [SVM_MEM_W-1:0] word_q;
  logic [SVM_MEM_W-1:0] word_d;

  // Contents come from the trained-model function in the package.
  always_comb begin
    word_d = word_q;
    if (rd_en) begin
      word_d = (int'(addr) < DEPTH) ? svm_model_word(int'(addr)) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/svm_sv_sequencer.sv
// Accepts one flow vector, streams every support vector from the SV ROM to
// the kernel, then drains before it will take the next vector.
import svm_sv_sequencer_pkg::*;

// state  | meaning
// IDLE   | waiting for a vector; in_ready high
// STREAM | issuing SV reads, paused while hold is high
// DRAIN  | last SV word returning, then one dead cycle
module svm_sv_sequencer #(
  parameter int SV_COUNT      = SVM_SV_COUNT,
  parameter int SV_ADDR_WIDTH = SVM_SV_ADDR_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [SVM_X_W-1:0]             in_x,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           hold,
  output logic [SV_ADDR_WIDTH-1:0]       sv_addr,
  output logic                           sv_rd_en,
  input  logic [SVM_MEM_W-1:0]           sv_word,
  output logic [SVM_X_W-1:0]             x,
  output logic [SVM_X_W-1:0]             sv,
  output logic [SVM_CLASS_WIDTH-1:0]     sv_class,
  output logic [SVM_COEF_W-1:0]          coef,
  output logic [SVM_COEF_SIGN_WIDTH-1:0] coef_sign,
  output logic                           data_valid,
  output logic                           new_computation,
  output logic                           last_sv
);

  localparam logic [SV_ADDR_WIDTH-1:0] LAST_ADDR = SV_ADDR_WIDTH'(SV_COUNT - 1);

  seq_state_e               state_q, state_d;
  logic [SV_ADDR_WIDTH-1:0] sv_addr_q, sv_addr_d;
  logic [SVM_X_W-1:0]       x_q, x_d;
  logic                     data_valid_q, data_valid_d;
  logic                     first_q, first_d;
  logic                     last_q, last_d;
  logic                     rd_en;

  always_comb begin
    state_d   = state_q;
    sv_addr_d = sv_addr_q;
    x_d       = x_q;
    rd_en     = 1'b0;
    in_ready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d       = in_x;
          sv_addr_d = '0;
          state_d   = ST_STREAM;
        end
      end
      ST_STREAM: begin
        rd_en = !hold;
        if (rd_en) begin
          // Address parks on the last SV; only a new acceptance clears it.
          if (sv_addr_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end else begin
            sv_addr_d = sv_addr_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!data_valid_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    data_valid_d = rd_en;
    first_d      = rd_en && (sv_addr_q == '0);
    last_d       = rd_en && (sv_addr_q == LAST_ADDR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      sv_addr_q    <= '0;
      x_q          <= '0;
      data_valid_q <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sv_addr_q    <= sv_addr_d;
      x_q          <= x_d;
      data_valid_q <= data_valid_d;
      first_q      <= first_d;
      last_q       <= last_d;
    end
  end

  assign sv_addr         = sv_addr_q;
  assign sv_rd_en        = rd_en;
  assign x               = x_q;
  assign data_valid      = data_valid_q;
  assign new_computation = first_q;
  assign last_sv         = last_q;

  // Operand fields are zeroed outside data_valid so the kernel sees clean zeros.
  assign sv        = data_valid_q ? sv_word[SVM_SV_LSB +: SVM_X_W] : '0;
  assign sv_class  = data_valid_q ? sv_word[SVM_CLASS_LSB +: SVM_CLASS_WIDTH] : '0;
  assign coef      = data_valid_q ? sv_word[SVM_COEF_LSB +: SVM_COEF_W] : '0;
  assign coef_sign = data_valid_q ? sv_word[SVM_SIGN_LSB +: SVM_COEF_SIGN_WIDTH] : '0;

endmodule

// File: tb/tb_svm_sv_sequencer.sv
// Bench for svm_sv_sequencer with its SV ROM; scoreboard plus per-scenario timing checks.
module tb_svm_sv_sequencer;
  import svm_sv_sequencer_pkg::*;

  localparam int N     = 4;
  localparam int EXP_W = SVM_MEM_W + 2;

  logic clk = 1'b0;
  logic reset;

  logic [SVM_X_W-1:0]             in_x;
  logic                           in_valid, in_ready, hold;
  logic [SVM_SV_ADDR_WIDTH-1:0]   sv_addr;
  logic                           sv_rd_en;
  logic [SVM_MEM_W-1:0]           sv_word;
  logic [SVM_X_W-1:0]             x, sv;
  logic [SVM_CLASS_WIDTH-1:0]     sv_class;
  logic [SVM_COEF_W-1:0]          coef;
  logic [SVM_COEF_SIGN_WIDTH-1:0] coef_sign;
  logic                           data_valid, new_computation, last_sv;

  logic [SVM_X_W-1:0]             in_x_1;
  logic                           in_valid_1, in_ready_1, hold_1;
  logic [0:0]                     sv_addr_1;
  logic                           sv_rd_en_1;
  logic [SVM_MEM_W-1:0]           sv_word_1;
  logic [SVM_X_W-1:0]             x_1, sv_1;
  logic [SVM_CLASS_WIDTH-1:0]     sv_class_1;
  logic [SVM_COEF_W-1:0]          coef_1;
  logic [SVM_COEF_SIGN_WIDTH-1:0] coef_sign_1;
  logic                           data_valid_1, new_computation_1, last_sv_1;

  int n_chk;
  int n_fail;
  int unsigned sb_q[$];
  int unsigned exp_idx;
  logic [SVM_X_W-1:0] exp_x;

  always #5 clk = ~clk;

  svm_sv_sequencer #(.SV_COUNT(N), .SV_ADDR_WIDTH(SVM_SV_ADDR_WIDTH)) dut (
    .clk(clk), .reset(reset), .in_x(in_x), .in_valid(in_valid), .in_ready(in_ready),
    .hold(hold), .sv_addr(sv_addr), .sv_rd_en(sv_rd_en), .sv_word(sv_word), .x(x),
    .sv(sv), .sv_class(sv_class), .coef(coef), .coef_sign(coef_sign),
    .data_valid(data_valid), .new_computation(new_computation), .last_sv(last_sv)
  );

  svm_sv_rom #(.DEPTH(N), .AW(SVM_SV_ADDR_WIDTH)) rom (
    .clk(clk), .reset(reset), .rd_en(sv_rd_en), .addr(sv_addr), .word(sv_word)
  );

  svm_sv_sequencer #(.SV_COUNT(1), .SV_ADDR_WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .in_x(in_x_1), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .hold(hold_1), .sv_addr(sv_addr_1), .sv_rd_en(sv_rd_en_1), .sv_word(sv_word_1), .x(x_1),
    .sv(sv_1), .sv_class(sv_class_1), .coef(coef_1), .coef_sign(coef_sign_1),
    .data_valid(data_valid_1), .new_computation(new_computation_1), .last_sv(last_sv_1)
  );

  svm_sv_rom #(.DEPTH(1), .AW(1)) rom1 (
    .clk(clk), .reset(reset), .rd_en(sv_rd_en_1), .addr(sv_addr_1), .word(sv_word_1)
  );

  // Expected kernel operands and strobes for SV index k of a vector of cnt SVs.
  function automatic logic [EXP_W-1:0] exp_word(input int unsigned k, input int unsigned cnt);
    logic [15:0] a, b, c, cf;
    logic [3:0]  cl;
    logic        nc, ls;
    a  = 16'h1000 + 16'(k);
    b  = 16'h2000 + 16'(k);
    c  = 16'h3000 + 16'(k);
    cf = 16'h0100 * 16'(k + 1);
    cl = 4'(k);
    nc = (k == 0);
    ls = (k == cnt - 1);
    return {a, b, c, cl, cf, 4'b1011, nc, ls};
  endfunction

  // Scoreboard: push on every issue, pop on every data_valid.
  always @(negedge clk) begin
    logic [EXP_W-1:0] got;
    int unsigned k;
    got = {sv, sv_class, coef, coef_sign, new_computation, last_sv};
    if (!reset) begin
      sb_q.delete();
      exp_idx = 0;
      exp_x   = '0;
    end else begin
      n_chk++;
      if (x !== exp_x) begin
        n_fail++;
        $display("FAIL sb_x: got %h expected %h", x, exp_x);
      end
      if (data_valid) begin
        n_chk++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: data_valid=1 with 0 issues outstanding, expected >=1");
        end else begin
          k = sb_q.pop_front();
          if (got !== exp_word(k, N)) begin
            n_fail++;
            $display("FAIL sb_word[%0d]: got %h expected %h", k, got, exp_word(k, N));
          end
        end
      end else begin
        n_chk++;
        if (got !== '0) begin
          n_fail++;
          $display("FAIL sb_idle_zero: got %h expected 0", got);
        end
      end
      if (sv_rd_en) begin
        n_chk++;
        if (sv_addr !== SVM_SV_ADDR_WIDTH'(exp_idx) || exp_idx >= N) begin
          n_fail++;
          $display("FAIL sb_issue_addr: got %0d expected %0d (limit %0d)", sv_addr, exp_idx, N - 1);
        end
        sb_q.push_back(exp_idx);
        exp_idx++;
      end
      if (in_valid && in_ready) begin
        exp_idx = 0;
        exp_x   = in_x;
      end
    end
  end

  task automatic start_vec(input logic [SVM_X_W-1:0] v);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_x     = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b0; hold = 1'b0; in_x = '0;
    in_valid_1 = 1'b0; hold_1 = 1'b0; in_x_1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({sv_addr, sv_rd_en, data_valid, new_computation, last_sv} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0", {sv_addr, sv_rd_en, data_valid, new_computation, last_sv});
    end
    n_chk++;
    if ({x, sv, sv_class, coef, coef_sign} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", {x, sv, sv_class, coef, coef_sign});
    end
    #1 reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1 || sv_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b sv_rd_en=%b expected 1,0", in_ready, sv_rd_en);
    end
  endtask

  task automatic test_basic;
    logic [SVM_X_W-1:0] v;
    logic [3:0] e, g;
    v = {16'd45, 16'd1200, 16'd128};
    start_vec(v);
    for (int j = 1; j <= 9; j++) begin
      if (j > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      e = {1'(j >= 2 && j <= 5), 1'(j == 2), 1'(j == 5), 1'(j >= 7)};
      g = {data_valid, new_computation, last_sv, in_ready};
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL basic_timing T+%0d: dv/nc/last/rdy got %b expected %b", j, g, e);
      end
      if (j >= 2 && j <= 5) begin
        n_chk++;
        if (sv_class !== 4'(j - 2)) begin
          n_fail++;
          $display("FAIL basic_class T+%0d: got %0d expected %0d", j, sv_class, j - 2);
        end
      end
      n_chk++;
      if (x !== v) begin
        n_fail++;
        $display("FAIL basic_x T+%0d: got %h expected %h", j, x, v);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [SVM_X_W-1:0] va, vb;
    int acc;
    va = {16'd1, 16'd2, 16'd3};
    vb = {16'd4, 16'd5, 16'd6};
    acc = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_x     = va;
    @(posedge clk);
    #1;
    in_x = vb;
    for (int j = 1; j <= 7; j++) begin
      if (j > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      n_chk++;
      if (in_ready !== 1'(j >= 7)) begin
        n_fail++;
        $display("FAIL b2b_ready T+%0d: got %b expected %b", j, in_ready, 1'(j >= 7));
      end
      if (in_ready && acc == 0) acc = j;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_chk++;
    if (acc != 7) begin
      n_fail++;
      $display("FAIL b2b_accept: second accepted at T+%0d expected T+7", acc);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (x !== vb) begin
      n_fail++;
      $display("FAIL b2b_x: got %h expected %h", x, vb);
    end
  endtask

  task automatic test_hold;
    logic [4:0] e, g;
    start_vec({16'd7, 16'd8, 16'd9});
    for (int j = 1; j <= 11; j++) begin
      if (j > 1) begin @(posedge clk); #1; end
      hold = (j >= 3 && j <= 5);
      @(negedge clk);
      e = {1'(j == 1 || j == 2 || j == 6 || j == 7), 1'(j == 2 || j == 3 || j == 7 || j == 8),
           1'(j == 2), 1'(j == 8), 1'(j >= 10)};
      g = {sv_rd_en, data_valid, new_computation, last_sv, in_ready};
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL hold_timing T+%0d: rd/dv/nc/last/rdy got %b expected %b", j, g, e);
      end
      if (j >= 3 && j <= 5) begin
        n_chk++;
        if (sv_addr !== 2'd2) begin
          n_fail++;
          $display("FAIL hold_addr T+%0d: got %0d expected 2", j, sv_addr);
        end
      end
    end
    hold = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid;
    start_vec({16'd11, 16'd12, 16'd13});
    for (int j = 1; j <= 6; j++) begin
      if (j > 1) begin @(posedge clk); #1; end
      reset = !(j == 3 || j == 4);
      @(negedge clk);
      if (j >= 3) begin
        n_chk++;
        if (data_valid !== 1'b0 || sv_addr !== '0 || in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL rstmid T+%0d: dv=%b addr=%0d rdy=%b expected 0,0,1", j, data_valid, sv_addr, in_ready);
        end
      end
    end
    start_vec({16'd21, 16'd22, 16'd23});
    @(negedge clk);
    n_chk++;
    if (sv_rd_en !== 1'b1 || sv_addr !== '0) begin
      n_fail++;
      $display("FAIL rstmid_restart_addr: rd=%b addr=%0d expected 1,0", sv_rd_en, sv_addr);
    end
    @(negedge clk);
    n_chk++;
    if (new_computation !== 1'b1 || data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_restart_nc: nc=%b dv=%b expected 1,1", new_computation, data_valid);
    end
    repeat (8) @(posedge clk);
  endtask

  task automatic test_ignore_valid;
    logic [SVM_X_W-1:0] ve, vf;
    int ncount;
    ve = {16'd31, 16'd32, 16'd33};
    vf = {16'd41, 16'd42, 16'd43};
    ncount = 0;
    start_vec(ve);
    for (int j = 1; j <= 10; j++) begin
      if (j > 1) begin @(posedge clk); #1; end
      in_valid = (j == 3);
      in_x     = (j == 3) ? vf : ve;
      @(negedge clk);
      if (j == 3) begin
        n_chk++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL ignore_ready: got %b expected 0", in_ready);
        end
      end
      if (new_computation) ncount++;
    end
    in_valid = 1'b0;
    n_chk++;
    if (ncount != 1) begin
      n_fail++;
      $display("FAIL ignore_nc_count: got %0d expected 1", ncount);
    end
  endtask

  task automatic test_sv_count_one;
    logic [SVM_X_W-1:0] vg;
    logic [3:0] e, g;
    vg = {16'd51, 16'd52, 16'd53};
    @(posedge clk);
    #1;
    in_valid_1 = 1'b1;
    in_x_1     = vg;
    @(posedge clk);
    #1;
    in_valid_1 = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      if (j > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      e = {1'(j == 2), 1'(j == 2), 1'(j == 2), 1'(j >= 4)};
      g = {data_valid_1, new_computation_1, last_sv_1, in_ready_1};
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL one_timing T+%0d: dv/nc/last/rdy got %b expected %b", j, g, e);
      end
      if (j == 2) begin
        n_chk++;
        if ({sv_class_1, coef_sign_1, x_1} !== {4'd0, 4'b1011, vg}) begin
          n_fail++;
          $display("FAIL one_word: class=%0d sign=%b x=%h expected 0,1011,%h", sv_class_1, coef_sign_1, x_1, vg);
        end
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_ignore_valid();
    test_sv_count_one();
    repeat (3) @(posedge clk);
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d outstanding expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
